// File: rtl/song_sequencer_pkg.sv
// Shared song-player definitions: ROM entry layout, octave codes, Notes bus type and FSM states.
package song_sequencer_pkg;

  typedef logic [8:0] notes_t;

  typedef struct packed {
    logic       eom;   // end-of-song marker
    logic [2:0] note;  // 0 = rest, 1..7 = note
    logic [1:0] oct;
    logic [9:0] dur;   // ticks, 0 plays as 1
  } song_entry_t;

  localparam logic [1:0] OCT_MID  = 2'b00;
  localparam logic [1:0] OCT_HIGH = 2'b01;
  localparam logic [1:0] OCT_LOW  = 2'b10;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StPlay, StGap} seq_state_e;

  // Reserved octave code falls through to mid (no octave bit).
  function automatic notes_t encode_notes(song_entry_t e);
    notes_t n;
    n = '0;
    if (e.note != 3'd0) begin
      n[e.note - 3'd1] = 1'b1;
      if (e.oct == OCT_HIGH) n[7] = 1'b1;
      else if (e.oct == OCT_LOW) n[8] = 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/song_sequencer_seq_tick_gen.sv
// Tick generator: one-cycle pulse every TICK_DIV enabled cycles, synchronous restart to zero.
module seq_tick_gen #(
  parameter int unsigned TICK_DIV = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntW'(TICK_DIV - 1));
  assign o_tick = i_en & w_wrap;

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song player: walks note entries in a synchronous ROM and drives the Notes bus per entry
// duration, with a silent articulation gap after each note.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DUR_W     = 10,
  parameter int unsigned TICK_DIV  = 500_000,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic              i_loop_en,
  input  logic [ADDR_W-1:0] i_song_base,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic [8:0]        o_notes,
  output logic              o_busy,
  output logic              o_paused,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_song_pos
);

  localparam int unsigned GapW = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] r_pos;
  notes_t            r_notes;
  logic              r_busy;
  logic              r_done;
  logic [DUR_W-1:0]  r_dur;
  logic [GapW-1:0]   r_gap;

  song_entry_t w_entry;
  logic        w_tick;
  logic        w_tick_en;
  logic        w_tick_restart;

  assign w_entry = song_entry_t'(i_rom_data);

  // Counter sits at zero outside PLAY/GAP, so every entry and gap starts a fresh tick period.
  assign w_tick_en      = r_busy & ~i_pause;
  assign w_tick_restart = (r_state != StPlay) && (r_state != StGap);

  seq_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_tick_en),
    .i_restart(w_tick_restart),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_base     <= '0;
      r_rom_addr <= '0;
      r_pos      <= '0;
      r_notes    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dur      <= '0;
      r_gap      <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_stop) begin
        r_state <= StIdle;
        r_notes <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            r_notes <= '0;
            if (i_start) begin
              r_base     <= i_song_base;
              r_rom_addr <= i_song_base;
              r_pos      <= '0;
              r_busy     <= 1'b1;
              r_state    <= StFetch;
            end
          end
          StFetch: r_state <= StWait;
          StWait: begin
            if (w_entry.eom) begin
              if (i_loop_en) begin
                r_rom_addr <= r_base;
                r_pos      <= '0;
                r_state    <= StFetch;
              end else begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end
            end else begin
              r_dur   <= (w_entry.dur == '0) ? DUR_W'(1) : DUR_W'(w_entry.dur);
              r_notes <= encode_notes(w_entry);
              r_state <= StPlay;
            end
          end
          StPlay: begin
            if (w_tick) begin
              if (r_dur == DUR_W'(1)) begin
                r_notes    <= '0;
                r_rom_addr <= r_rom_addr + 1'b1;
                r_pos      <= r_pos + 1'b1;
                if (GAP_TICKS == 0) begin
                  r_state <= StFetch;
                end else begin
                  r_gap   <= GapW'(GAP_TICKS);
                  r_state <= StGap;
                end
              end else begin
                r_dur <= r_dur - 1'b1;
              end
            end
          end
          StGap: begin
            if (w_tick) begin
              if (r_gap == GapW'(1)) r_state <= StFetch;
              else r_gap <= r_gap - 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_rom_addr = r_rom_addr;
  assign o_notes    = r_notes;
  assign o_busy     = r_busy;
  assign o_paused   = r_busy & i_pause;
  assign o_done     = r_done;
  assign o_song_pos = r_pos;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: table-checked playback timeline plus pause, loop, stop,
// rest/wrap and mid-song reset sequences.
module tb_song_sequencer;

  logic        clk;
  logic        rst;
  logic        i_start, i_stop, i_pause, i_loop_en;
  logic [9:0]  i_song_base;
  logic [9:0]  o_rom_addr;
  logic [15:0] rom_data;
  logic [8:0]  o_notes;
  logic        o_busy, o_paused, o_done;
  logic [9:0]  o_song_pos;

  logic [15:0] rom [1024];

  int n_tests;
  int n_fail;

  logic [8:0] cap_notes [64];
  logic       cap_busy  [64];
  logic       cap_done  [64];
  logic [9:0] cap_pos   [64];
  logic [9:0] cap_addr  [64];

  typedef struct {
    int         n;
    logic [8:0] notes;
    logic       busy;
    logic       done;
    logic [9:0] pos;
  } vec_t;

  vec_t vecs [12];

  song_sequencer #(
    .ADDR_W   (10),
    .DUR_W    (10),
    .TICK_DIV (4),
    .GAP_TICKS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_pause    (i_pause),
    .i_loop_en  (i_loop_en),
    .i_song_base(i_song_base),
    .o_rom_addr (o_rom_addr),
    .i_rom_data (rom_data),
    .o_notes    (o_notes),
    .o_busy     (o_busy),
    .o_paused   (o_paused),
    .o_done     (o_done),
    .o_song_pos (o_song_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[o_rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulses start across one posedge; returns at the sample point of cycle 0 after start.
  task automatic start_song(input logic [9:0] base);
    i_song_base = base;
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic capture(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      cap_notes[c] = o_notes;
      cap_busy[c]  = o_busy;
      cap_done[c]  = o_done;
      cap_pos[c]   = o_song_pos;
      cap_addr[c]  = o_rom_addr;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name, input int limit);
    int k;
    k = 0;
    while (!o_done && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, o_done}, 32'd1);
  endtask

  task automatic stop_pulse();
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_pause = 1'b0; i_loop_en = 1'b0;
    i_song_base = '0;
    for (int a = 0; a < 1024; a++) rom[a] = 16'h0000;
    // Main song at 0x010: C mid dur3, E high dur1, END
    rom[10'h010] = 16'h1003;
    rom[10'h011] = 16'h3401;
    rom[10'h012] = 16'h8000;
    // Wrap song at 0x3FF: rest dur0, then END at 0x000
    rom[10'h3FF] = 16'h0000;
    rom[10'h000] = 16'h8000;

    vecs[0]  = '{0,  9'h000, 1'b1, 1'b0, 10'd0};
    vecs[1]  = '{1,  9'h000, 1'b1, 1'b0, 10'd0};
    vecs[2]  = '{2,  9'h001, 1'b1, 1'b0, 10'd0};
    vecs[3]  = '{13, 9'h001, 1'b1, 1'b0, 10'd0};
    vecs[4]  = '{14, 9'h000, 1'b1, 1'b0, 10'd1};
    vecs[5]  = '{23, 9'h000, 1'b1, 1'b0, 10'd1};
    vecs[6]  = '{24, 9'h084, 1'b1, 1'b0, 10'd1};
    vecs[7]  = '{27, 9'h084, 1'b1, 1'b0, 10'd1};
    vecs[8]  = '{28, 9'h000, 1'b1, 1'b0, 10'd2};
    vecs[9]  = '{37, 9'h000, 1'b1, 1'b0, 10'd2};
    vecs[10] = '{38, 9'h000, 1'b0, 1'b1, 10'd2};
    vecs[11] = '{39, 9'h000, 1'b0, 1'b0, 10'd2};

    @(negedge clk);
    @(negedge clk);
    check("reset_notes", {23'd0, o_notes}, 32'd0);
    check("reset_addr", {22'd0, o_rom_addr}, 32'd0);
    check("reset_pos", {22'd0, o_song_pos}, 32'd0);
    check("reset_flags", {29'd0, o_busy, o_paused, o_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full playback timeline, compared against the vector table
    start_song(10'h010);
    capture(40);
    check("main_addr0", {22'd0, cap_addr[0]}, 32'h010);
    for (int v = 0; v < 12; v++) begin
      check($sformatf("main_notes_n%0d", vecs[v].n), {23'd0, cap_notes[vecs[v].n]},
            {23'd0, vecs[v].notes});
      check($sformatf("main_busy_n%0d", vecs[v].n), {31'd0, cap_busy[vecs[v].n]},
            {31'd0, vecs[v].busy});
      check($sformatf("main_done_n%0d", vecs[v].n), {31'd0, cap_done[vecs[v].n]},
            {31'd0, vecs[v].done});
      check($sformatf("main_pos_n%0d", vecs[v].n), {22'd0, cap_pos[vecs[v].n]},
            {22'd0, vecs[v].pos});
    end
    repeat (2) @(negedge clk);

    // Pause 20 cycles mid-C: note sustains and its total length becomes 32 cycles
    start_song(10'h010);
    repeat (5) @(negedge clk);
    i_pause = 1'b1;
    repeat (10) @(negedge clk);
    check("pause_notes_hold", {23'd0, o_notes}, 32'h001);
    check("pause_paused", {31'd0, o_paused}, 32'd1);
    check("pause_pos_frozen", {22'd0, o_song_pos}, 32'd0);
    repeat (10) @(negedge clk);
    i_pause = 1'b0;
    repeat (8) @(negedge clk);
    check("pause_c_end_minus1", {23'd0, o_notes}, 32'h001);
    check("pause_unpaused", {31'd0, o_paused}, 32'd0);
    @(negedge clk);
    check("pause_c_end", {23'd0, o_notes}, 32'h000);
    check("pause_pos_after", {22'd0, o_song_pos}, 32'd1);
    wait_done("pause_done", 60);
    repeat (2) @(negedge clk);

    // Looping: END sends the address back to song_base without a done pulse
    i_loop_en = 1'b1;
    start_song(10'h010);
    capture(41);
    check("loop_no_done", {31'd0, cap_done[38]}, 32'd0);
    check("loop_busy", {31'd0, cap_busy[38]}, 32'd1);
    check("loop_addr", {22'd0, cap_addr[38]}, 32'h010);
    check("loop_pos", {22'd0, cap_pos[38]}, 32'd0);
    check("loop_replay", {23'd0, cap_notes[40]}, 32'h001);
    i_loop_en = 1'b0;
    stop_pulse();
    check("loop_stopped", {31'd0, o_busy}, 32'd0);

    // Stop during GAP, then start+stop together
    start_song(10'h010);
    repeat (15) @(negedge clk);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    check("stop_busy", {31'd0, o_busy}, 32'd0);
    check("stop_notes", {23'd0, o_notes}, 32'd0);
    check("stop_no_done", {31'd0, o_done}, 32'd0);
    repeat (12) @(negedge clk);
    check("stop_stays_idle", {31'd0, o_busy, o_done}, 32'd0);
    i_start = 1'b1;
    i_stop  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_stop  = 1'b0;
    check("startstop_busy", {31'd0, o_busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("startstop_idle", {31'd0, o_busy}, 32'd0);

    // Rest with duration 0 at 0x3FF: one tick of silence, next fetch wraps to 0x000
    start_song(10'h3FF);
    capture(17);
    check("rest_addr0", {22'd0, cap_addr[0]}, 32'h3FF);
    check("rest_notes", {23'd0, cap_notes[3]}, 32'd0);
    check("rest_addr_n5", {22'd0, cap_addr[5]}, 32'h3FF);
    check("rest_wrap_n6", {22'd0, cap_addr[6]}, 32'h000);
    check("rest_pos_n6", {22'd0, cap_pos[6]}, 32'd1);
    check("rest_done_n16", {31'd0, cap_done[16]}, 32'd1);
    repeat (2) @(negedge clk);

    // Reset mid-PLAY, then a normal start
    start_song(10'h010);
    repeat (5) @(negedge clk);
    check("rst_pre_notes", {23'd0, o_notes}, 32'h001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_notes", {23'd0, o_notes}, 32'd0);
    check("rst_addr", {22'd0, o_rom_addr}, 32'd0);
    check("rst_pos", {22'd0, o_song_pos}, 32'd0);
    check("rst_flags", {29'd0, o_busy, o_paused, o_done}, 32'd0);
    @(negedge clk);
    start_song(10'h010);
    capture(3);
    check("rst_restart_notes", {23'd0, cap_notes[2]}, 32'h001);
    wait_done("rst_restart_done", 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
